// File: rtl/cpack_pkg.sv
// cpack shared types, code constants and per-word encoder.
// Imported by the compressor and by the line decompressor.
package cpack_pkg;

  localparam int WIDTH_DATA_IN = 128;
  localparam int WIDTH         = 32;
  localparam int WORD          = 16;
  localparam int LENGTH_CODE   = 2;
  localparam int TOTAL_LENGTH  = 8;

  typedef logic [LENGTH_CODE-1:0] code_t;

  localparam code_t CODE_ZERO    = 2'b00;
  localparam code_t CODE_MATCH   = 2'b01;
  localparam code_t CODE_PARTIAL = 2'b11;
  localparam code_t CODE_RAW     = 2'b10;

  typedef logic [TOTAL_LENGTH-1:0] len_t;

  localparam len_t LEN_ZERO    = 8'd2;
  localparam len_t LEN_MATCH   = 8'd6;
  localparam len_t LEN_PARTIAL = 8'd14;
  localparam len_t LEN_RAW     = 8'd34;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PAIR0 = 2'd1,
    ST_PAIR1 = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  // One encoded word: code bits LSB-first, length, dictionary push.
  typedef struct packed {
    logic [33:0] bits;
    len_t        len;
    logic        push;
  } enc_t;

  // Zero > full match > partial match > raw; lowest index wins.
  function automatic enc_t encode_word(
    input logic [WIDTH-1:0]      w,
    input logic [WORD*WIDTH-1:0] dict
  );
    enc_t             e;
    logic             full_hit;
    logic             part_hit;
    logic [3:0]       full_idx;
    logic [3:0]       part_idx;
    logic [WIDTH-1:0] ent;
    e        = '0;
    full_hit = 1'b0;
    part_hit = 1'b0;
    full_idx = '0;
    part_idx = '0;
    // Descending scan so the lowest hitting index is the last written.
    for (int i = WORD - 1; i >= 0; i--) begin
      ent = dict[i*WIDTH +: WIDTH];
      if (ent == w) begin
        full_hit = 1'b1;
        full_idx = 4'(i);
      end
      if (ent[31:8] == w[31:8]) begin
        part_hit = 1'b1;
        part_idx = 4'(i);
      end
    end
    if (w == '0) begin
      e.bits = {32'd0, CODE_ZERO};
      e.len  = LEN_ZERO;
    end else if (full_hit) begin
      e.bits = {28'd0, full_idx, CODE_MATCH};
      e.len  = LEN_MATCH;
    end else if (part_hit) begin
      e.bits = {20'd0, w[7:0], part_idx, CODE_PARTIAL};
      e.len  = LEN_PARTIAL;
      e.push = 1'b1;
    end else begin
      e.bits = {w, CODE_RAW};
      e.len  = LEN_RAW;
      e.push = 1'b1;
    end
    return e;
  endfunction

endpackage

// File: rtl/cpack_dict.sv
// cpack 16x32 FIFO dictionary with dual push and
// shadow snapshot/restore for raw-line rollback.
module cpack_dict
  import cpack_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_snap,
  input  logic                  i_restore,
  input  logic                  i_push0,
  input  logic                  i_push1,
  input  logic [WIDTH-1:0]      i_word0,
  input  logic [WIDTH-1:0]      i_word1,
  output logic [WORD*WIDTH-1:0] o_dict
);

  logic [WIDTH-1:0] dict_q   [WORD];
  logic [WIDTH-1:0] dict_d   [WORD];
  logic [WIDTH-1:0] shadow_q [WORD];
  logic [3:0]       wr_ptr_q;
  logic [3:0]       wr_ptr_d;
  logic [3:0]       shadow_ptr_q;
  logic [3:0]       ptr1;

  // Next dictionary: pushes in word order, restore overrides.
  always_comb begin
    dict_d   = dict_q;
    ptr1     = wr_ptr_q + 4'(i_push0);
    wr_ptr_d = ptr1 + 4'(i_push1);
    if (i_push0) dict_d[wr_ptr_q] = i_word0;
    if (i_push1) dict_d[ptr1]     = i_word1;
    if (i_restore) begin
      dict_d   = shadow_q;
      wr_ptr_d = shadow_ptr_q;
    end
  end

  // Dictionary, pointer and shadow registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < WORD; i++) begin
        dict_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      shadow_ptr_q <= '0;
    end else begin
      dict_q   <= dict_d;
      wr_ptr_q <= wr_ptr_d;
      if (i_snap) begin
        shadow_q     <= dict_q;
        shadow_ptr_q <= wr_ptr_q;
      end
    end
  end

  for (genvar g = 0; g < WORD; g++) begin : g_flat
    assign o_dict[g*WIDTH +: WIDTH] = dict_q[g];
  end

endmodule

// File: rtl/cpack_compressor.sv
// cpack line compressor: two words per cycle against
// a FIFO dictionary, LSB-first packed output.
module cpack_compressor
  import cpack_pkg::*;
(
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [WIDTH_DATA_IN-1:0] i_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [WIDTH_DATA_IN-1:0] o_data,
  output logic                     o_comp_flag,
  output logic [TOTAL_LENGTH-1:0]  o_length
);

  state_t                   state_q;
  state_t                   state_d;
  logic [WIDTH_DATA_IN-1:0] line_q;
  logic [WIDTH_DATA_IN-1:0] data_q;
  logic [135:0]             pack_q;
  logic [135:0]             pack_d;
  len_t                     acc_q;
  len_t                     len_q;
  len_t                     sum0;
  len_t                     sum1;
  logic                     flag_q;
  logic                     busy;
  logic                     overflow;
  logic [WIDTH-1:0]         w0;
  logic [WIDTH-1:0]         w1;
  logic [WORD*WIDTH-1:0]    dict_flat;
  enc_t                     enc0;
  enc_t                     enc1;

  // Encode the current pair and compute packing.
  always_comb begin
    busy     = (state_q == ST_PAIR0) || (state_q == ST_PAIR1);
    w0       = (state_q == ST_PAIR1) ? line_q[95:64]  : line_q[31:0];
    w1       = (state_q == ST_PAIR1) ? line_q[127:96] : line_q[63:32];
    enc0     = encode_word(w0, dict_flat);
    enc1     = encode_word(w1, dict_flat);
    sum0     = acc_q + enc0.len;
    sum1     = sum0 + enc1.len;
    pack_d   = pack_q
             | (136'(enc0.bits) << acc_q)
             | (136'(enc1.bits) << sum0);
    overflow = sum1 > 8'd128;
  end

  cpack_dict u_dict (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_snap    ((state_q == ST_IDLE) && i_valid),
    .i_restore ((state_q == ST_PAIR1) && overflow),
    .i_push0   (busy && enc0.push),
    .i_push1   (busy && enc1.push),
    .i_word0   (w0),
    .i_word1   (w1),
    .o_dict    (dict_flat)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (i_valid) state_d = ST_PAIR0;
      ST_PAIR0: state_d = ST_PAIR1;
      ST_PAIR1: state_d = ST_OUT;
      ST_OUT:   if (i_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    o_ready = (state_q == ST_IDLE);
    o_valid = (state_q == ST_OUT);
  end

  // Line capture, bit accumulation and result registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      line_q <= '0;
      pack_q <= '0;
      acc_q  <= '0;
      data_q <= '0;
      flag_q <= 1'b0;
      len_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_valid) begin
            line_q <= i_data;
            pack_q <= '0;
            acc_q  <= '0;
          end
        end
        ST_PAIR0: begin
          pack_q <= pack_d;
          acc_q  <= sum1;
        end
        ST_PAIR1: begin
          data_q <= overflow ? line_q : pack_d[127:0];
          flag_q <= !overflow;
          len_q  <= overflow ? 8'd128 : sum1;
        end
        default: ;
      endcase
    end
  end

  assign o_data      = data_q;
  assign o_comp_flag = flag_q;
  assign o_length    = len_q;

endmodule
